vga_timing_param: RTL

Parametrised successor to the fixed 640x480 XVGA timing generator. Produces the raster counters, sync and blank signals for any porch, sync and active geometry, with selectable sync polarity. Sync and blank are delayed by a configurable number of cycles so they align with the downstream pixel pipeline (YCrCb LUT, output registers). A lookahead request position, PREFETCH cycles ahead, lets the frame-buffer read side (vga_write FIFO) fetch pixels early. Sits in the vclock domain, between reset logic and the VGA pixel output path.

---
 rtl/vga_timing_param.sv | 142 ++++++++++++++
 1 files changed

// File: rtl/vga_timing_param.sv
// Parametrised VGA raster timing generator: counters, delayed sync/blank and a
// lookahead request position for early frame-buffer fetch.
module vga_timing_param #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FP       = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BP       = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FP       = 11,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BP       = 31,
    parameter int unsigned HCOUNT_W   = 10,
    parameter int unsigned VCOUNT_W   = 10,
    parameter logic        SYNC_POL   = 1'b0,
    parameter int unsigned PIPE_DELAY = 2,
    parameter int unsigned PREFETCH   = 4
) (
    input  logic                vclock,
    input  logic                reset,
    input  logic                enable,
    output logic [HCOUNT_W-1:0] hcount,
    output logic [VCOUNT_W-1:0] vcount,
    output logic                active,
    output logic                line_start,
    output logic                frame_start,
    output logic                hsync,
    output logic                vsync,
    output logic                blank_b,
    output logic                req_valid,
    output logic [HCOUNT_W-1:0] req_hcount,
    output logic [VCOUNT_W-1:0] req_vcount
);

    localparam int unsigned H_TOTAL  = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int unsigned V_TOTAL  = V_ACTIVE + V_FP + V_SYNC + V_BP;
    localparam int unsigned HS_START = H_ACTIVE + H_FP;
    localparam int unsigned HS_END   = H_ACTIVE + H_FP + H_SYNC;
    localparam int unsigned VS_START = V_ACTIVE + V_FP;
    localparam int unsigned VS_END   = V_ACTIVE + V_FP + V_SYNC;

    localparam logic [HCOUNT_W-1:0] H_LAST     = HCOUNT_W'(H_TOTAL - 1);
    localparam logic [VCOUNT_W-1:0] V_LAST     = VCOUNT_W'(V_TOTAL - 1);
    localparam logic [HCOUNT_W-1:0] H_PREFETCH = HCOUNT_W'(PREFETCH);

    // Illegal geometry stops elaboration rather than producing a silently wrong raster.
    if (PIPE_DELAY < 1 || PIPE_DELAY > 8) begin : g_bad_pipe_delay
        $error("vga_timing_param: PIPE_DELAY=%0d outside 1..8", PIPE_DELAY);
    end
    if (PREFETCH < 1 || PREFETCH > H_FP + H_SYNC + H_BP - 1) begin : g_bad_prefetch
        $error("vga_timing_param: PREFETCH=%0d outside 1..%0d", PREFETCH, H_FP + H_SYNC + H_BP - 1);
    end
    if ((64'd1 << HCOUNT_W) < 64'(H_TOTAL)) begin : g_bad_hcount_w
        $error("vga_timing_param: HCOUNT_W=%0d too small for H_TOTAL=%0d", HCOUNT_W, H_TOTAL);
    end
    if ((64'd1 << VCOUNT_W) < 64'(V_TOTAL)) begin : g_bad_vcount_w
        $error("vga_timing_param: VCOUNT_W=%0d too small for V_TOTAL=%0d", VCOUNT_W, V_TOTAL);
    end

    logic [HCOUNT_W-1:0]   hcount_q, hcount_d;
    logic [VCOUNT_W-1:0]   vcount_q, vcount_d;
    logic [HCOUNT_W-1:0]   rh_q, rh_d;
    logic [VCOUNT_W-1:0]   rv_q, rv_d;
    logic [PIPE_DELAY-1:0] hs_pipe_q, hs_pipe_d;
    logic [PIPE_DELAY-1:0] vs_pipe_q, vs_pipe_d;
    logic [PIPE_DELAY-1:0] act_pipe_q, act_pipe_d;
    logic                  act_raw, hs_raw, vs_raw;

    // Raster step shared by the display counters and the lookahead counters.
    function automatic logic [VCOUNT_W+HCOUNT_W-1:0] advance(
        input logic [HCOUNT_W-1:0] h,
        input logic [VCOUNT_W-1:0] v
    );
        logic [HCOUNT_W-1:0] h_n;
        logic [VCOUNT_W-1:0] v_n;
        h_n = h + HCOUNT_W'(1);
        v_n = v;
        if (h == H_LAST) begin
            h_n = '0;
            v_n = (v == V_LAST) ? '0 : v + VCOUNT_W'(1);
        end
        return {v_n, h_n};
    endfunction

    always_comb begin
        {vcount_d, hcount_d} = advance(hcount_q, vcount_q);
        {rv_d, rh_d}         = advance(rh_q, rv_q);
    end

    always_comb begin
        act_raw = (32'(hcount_q) < H_ACTIVE) && (32'(vcount_q) < V_ACTIVE);
        hs_raw  = (32'(hcount_q) >= HS_START) && (32'(hcount_q) < HS_END);
        vs_raw  = (32'(vcount_q) >= VS_START) && (32'(vcount_q) < VS_END);
    end

    // Pipes hold "asserted" as 1; polarity is applied only at the outputs.
    always_comb begin
        hs_pipe_d     = hs_pipe_q;
        vs_pipe_d     = vs_pipe_q;
        act_pipe_d    = act_pipe_q;
        hs_pipe_d[0]  = hs_raw;
        vs_pipe_d[0]  = vs_raw;
        act_pipe_d[0] = act_raw;
        for (int unsigned i = 1; i < PIPE_DELAY; i++) begin
            hs_pipe_d[i]  = hs_pipe_q[i-1];
            vs_pipe_d[i]  = vs_pipe_q[i-1];
            act_pipe_d[i] = act_pipe_q[i-1];
        end
    end

    always_ff @(posedge vclock) begin
        if (reset) begin
            hcount_q   <= '0;
            vcount_q   <= '0;
            rh_q       <= H_PREFETCH;
            rv_q       <= '0;
            hs_pipe_q  <= '0;
            vs_pipe_q  <= '0;
            act_pipe_q <= '0;
        end else if (enable) begin
            hcount_q   <= hcount_d;
            vcount_q   <= vcount_d;
            rh_q       <= rh_d;
            rv_q       <= rv_d;
            hs_pipe_q  <= hs_pipe_d;
            vs_pipe_q  <= vs_pipe_d;
            act_pipe_q <= act_pipe_d;
        end
    end

    assign hcount      = hcount_q;
    assign vcount      = vcount_q;
    assign active      = act_raw;
    assign line_start  = enable && !reset && (hcount_q == '0);
    assign frame_start = enable && !reset && (hcount_q == '0) && (vcount_q == '0);
    assign hsync       = hs_pipe_q[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
    assign vsync       = vs_pipe_q[PIPE_DELAY-1] ? SYNC_POL : ~SYNC_POL;
    assign blank_b     = act_pipe_q[PIPE_DELAY-1];
    assign req_hcount  = rh_q;
    assign req_vcount  = rv_q;
    assign req_valid   = (32'(rh_q) < H_ACTIVE) && (32'(rv_q) < V_ACTIVE);

endmodule
